fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_unit_branch_target_calc.sv | 19 +
 rtl/fetch_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared processor package: fetch FSM state encoding, default NOP word
// and the sequential program-counter step used by the fetch unit.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES       = 32'd4;

    // Sequential successor of an instruction address, wrapping modulo 2^32.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/fetch_unit_branch_target_calc.sv
// Branch target computation: either the register-bank link value or the
// PC-relative target, where the offset is counted in words.
module branch_target_calc (
    input  logic [31:0] pc,
    input  logic [31:0] offset_words,
    input  logic [31:0] link_addr,
    input  logic        to_link,
    output logic [31:0] target
);

    // Word offset becomes a byte offset; the sum wraps modulo 2^32.
    always_comb begin
        target = pc + (offset_words << 2);
        if (to_link) begin
            target = link_addr;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch unit. Holds one fetched
// instruction for decode and redirects the next fetch on taken branches.
// No fetch is ever speculative, so a redirect never needs a flush.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        should_branch,
    input  logic        should_branch_to_link,
    input  logic        should_store_link,
    input  logic        cond_pass,
    input  logic [31:0] extended_immediate,
    input  logic [31:0] link_addr,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic        link_we,
    output logic [31:0] link_pc
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [31:0] fetch_pc;
    logic [31:0] instr_reg;
    logic [31:0] branch_target;
    logic        accept;
    logic        consume;
    logic        taken;

    branch_target_calc u_target (
        .pc           (pc_out),
        .offset_words (extended_immediate),
        .link_addr    (link_addr),
        .to_link      (should_branch_to_link),
        .target       (branch_target)
    );

    // State register; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the handshake and branch strobes.
    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        accept      = 1'b0;
        consume     = 1'b0;
        case (state)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    accept     = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    consume    = 1'b1;
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        taken   = consume && should_branch && cond_pass;
        link_we = taken && should_store_link;
    end

    // Fetch address, held instruction and its address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc  <= RESET_PC;
            pc_out    <= RESET_PC;
            instr_reg <= NOP_INSTR;
        end else if (accept) begin
            instr_reg <= imem_rdata;
            pc_out    <= fetch_pc;
            fetch_pc  <= next_seq_pc(fetch_pc);
        end else if (taken) begin
            fetch_pc  <= branch_target;
        end
    end

    // Address outputs and the NOP substitution while nothing is held.
    always_comb begin
        imem_addr = fetch_pc;
        link_pc   = next_seq_pc(pc_out);
        instr_out = NOP_INSTR;
        if (instr_valid) begin
            instr_out = instr_reg;
        end
    end

endmodule
